// File: rtl/demux_y_adc_16ch.sv
// Receive-side de-interleaver: steers a serial sample stream into
// NCH channel slots and hands out complete frames over valid/ready.
module demux_y_adc_16ch #(
  parameter int DW  = 32,
  parameter int NCH = 16,
  parameter int CW  = 4
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic [DW-1:0]     y_in,
  input  logic              y_valid,
  input  logic              y_sync,
  output logic [CW-1:0]     ch_sel,
  output logic [NCH*DW-1:0] y_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun
);

  // The last slot is never stored: it is merged straight from y_in.
  logic [DW-1:0]     bank_q [NCH-1];
  logic [DW-1:0]     bank_d [NCH-1];
  logic [CW-1:0]     ch_sel_q, ch_sel_d;
  logic [NCH*DW-1:0] y_out_q, y_out_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic              complete;
  logic              accept;

  always_comb begin
    bank_d      = bank_q;
    ch_sel_d    = ch_sel_q;
    y_out_d     = y_out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    complete    = 1'b0;
    accept      = out_valid_q && out_ready;

    unique case (1'b1)
      y_sync && y_valid: begin
        bank_d[0] = y_in;
        ch_sel_d  = CW'(1);
      end
      y_sync && !y_valid: begin
        ch_sel_d = '0;
      end
      !y_sync && y_valid: begin
        ch_sel_d = ch_sel_q + CW'(1);
        if (ch_sel_q == CW'(NCH-1)) begin
          complete = 1'b1;
        end else begin
          bank_d[ch_sel_q] = y_in;
        end
      end
      default: begin
      end
    endcase

    if (complete) begin
      for (int k = 0; k < NCH-1; k++) begin
        y_out_d[k*DW +: DW] = bank_q[k];
      end
      y_out_d[(NCH-1)*DW +: DW] = y_in;
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      bank_q      <= '{default: '0};
      ch_sel_q    <= '0;
      y_out_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      ch_sel_q    <= ch_sel_d;
      y_out_q     <= y_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign ch_sel    = ch_sel_q;
  assign y_out     = y_out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_demux_y_adc_16ch.sv
// Randomised scoreboard bench for demux_y_adc_16ch against a
// list-based frame model.
module tb_demux_y_adc_16ch;
  localparam int DW  = 32;
  localparam int NCH = 16;
  localparam int CW  = 4;

  logic              clk = 1'b0;
  logic              GlobalReset = 1'b1;
  logic [DW-1:0]     y_in = '0;
  logic              y_valid = 1'b0;
  logic              y_sync = 1'b0;
  logic              out_ready = 1'b0;
  logic [CW-1:0]     ch_sel;
  logic [NCH*DW-1:0] y_out;
  logic              out_valid;
  logic              overrun;

  demux_y_adc_16ch #(.DW(DW), .NCH(NCH), .CW(CW)) dut (
    .clk(clk),
    .GlobalReset(GlobalReset),
    .y_in(y_in),
    .y_valid(y_valid),
    .y_sync(y_sync),
    .ch_sel(ch_sel),
    .y_out(y_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0]     ch;
    logic              vld;
    logic              ovr;
    logic [NCH*DW-1:0] dat;
  } st_t;

  int vectors = 0;
  int errors  = 0;

  logic [DW-1:0]     col [$];
  logic [NCH*DW-1:0] fq [$];
  st_t               sq [$];
  logic [NCH*DW-1:0] m_frame = '0;
  bit                m_valid = 0;
  bit                m_over  = 0;

  task automatic chk(input string n,
                     input logic [NCH*DW-1:0] act,
                     input logic [NCH*DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Drive one cycle and advance the model past the coming edge.
  task automatic cyc(input bit yv, input bit ys,
                     input logic [DW-1:0] yi,
                     input bit rdy, input bit rst);
    bit done;
    bit acc;
    st_t e;
    @(negedge clk);
    GlobalReset = rst;
    y_valid     = yv;
    y_sync      = ys;
    y_in        = yi;
    out_ready   = rdy;
    if (rst) begin
      col.delete();
      m_frame = '0;
      m_valid = 0;
      m_over  = 0;
    end else begin
      acc  = m_valid && rdy;
      done = 0;
      if (acc) fq.push_back(m_frame);
      if (ys) begin
        col.delete();
        if (yv) col.push_back(yi);
      end else if (yv) begin
        col.push_back(yi);
        if (col.size() == NCH) done = 1;
      end
      if (done) begin
        if (m_valid && !rdy) m_over = 1;
        for (int k = 0; k < NCH; k++) m_frame[k*DW +: DW] = col[k];
        col.delete();
        m_valid = 1;
      end else if (acc) begin
        m_valid = 0;
      end
    end
    e.ch  = CW'(col.size());
    e.vld = m_valid;
    e.ovr = m_over;
    e.dat = m_frame;
    sq.push_back(e);
  endtask

  task automatic frame(input logic [DW-1:0] base,
                       input bit rdy, input bit gaps);
    for (int k = 0; k < NCH; k++) begin
      cyc(1, 0, base + DW'(k), rdy, 0);
      if (gaps) begin
        int g = $urandom_range(1, 3);
        for (int j = 0; j < g; j++) cyc(0, 0, $urandom, rdy, 0);
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int j = 0; j < n; j++) cyc(0, 0, '0, rdy, 0);
  endtask

  logic              prev_valid;
  logic [NCH*DW-1:0] prev_yout;

  always @(posedge clk) begin
    st_t e;
    logic [NCH*DW-1:0] ef;
    #1;
    if (!GlobalReset && prev_valid === 1'b1 && out_ready) begin
      if (fq.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL accept: got unexpected frame %h expected none",
                 prev_yout);
      end else begin
        ef = fq.pop_front();
        chk("frame", prev_yout, ef);
      end
    end
    if (sq.size() != 0) begin
      e = sq.pop_front();
      chk("ch_sel", {{(NCH*DW-CW){1'b0}}, ch_sel}, {{(NCH*DW-CW){1'b0}}, e.ch});
      chk("out_valid", {{(NCH*DW-1){1'b0}}, out_valid}, {{(NCH*DW-1){1'b0}}, e.vld});
      chk("overrun", {{(NCH*DW-1){1'b0}}, overrun}, {{(NCH*DW-1){1'b0}}, e.ovr});
      chk("y_out", y_out, e.dat);
    end
    prev_valid = out_valid;
    prev_yout  = y_out;
  end

  initial begin
    cyc(0, 0, '0, 0, 1);
    cyc(0, 0, '0, 1, 1);
    // back-to-back frame, always ready
    frame(32'h100, 1, 0);
    idle(3, 1);
    // same frame with gaps
    frame(32'h100, 1, 1);
    idle(3, 1);
    // resync mid-frame
    for (int k = 0; k < 5; k++) cyc(1, 0, 32'h50 + DW'(k), 1, 0);
    cyc(1, 1, 32'hA0, 1, 0);
    for (int k = 1; k < NCH; k++) cyc(1, 0, 32'hA0 + DW'(k), 1, 0);
    idle(3, 1);
    // sync without data, then a frame
    cyc(1, 0, 32'h77, 1, 0);
    cyc(0, 1, 32'h0, 1, 0);
    frame(32'h300, 1, 0);
    idle(2, 1);
    // overrun: two frames, never ready
    frame(32'h100, 0, 0);
    frame(32'h200, 0, 0);
    idle(4, 0);
    idle(2, 1);
    idle(3, 0);
    cyc(0, 0, '0, 0, 1);
    // accept and completion on the same edge
    frame(32'h400, 0, 0);
    for (int k = 0; k < NCH-1; k++) cyc(1, 0, 32'h500 + DW'(k), 0, 0);
    cyc(1, 0, 32'h50F, 1, 0);
    idle(2, 0);
    idle(2, 1);
    // reset mid-frame while a frame is pending
    frame(32'h600, 0, 0);
    for (int k = 0; k < 9; k++) cyc(1, 0, 32'h700 + DW'(k), 0, 0);
    cyc(1, 0, 32'h7FF, 1, 1);
    frame(32'h800, 1, 0);
    idle(3, 1);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bit yv  = ($urandom_range(0, 9) < 7);
      bit ys  = ($urandom_range(0, 99) < 3);
      bit rdy = ($urandom_range(0, 1) == 1);
      bit rst = ($urandom_range(0, 199) == 0);
      cyc(yv, ys, $urandom, rdy, rst);
    end
    idle(4, 1);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (fq.size() != 0 || sq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d frames %0d states left expected 0",
               fq.size(), sq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
